// File: rtl/mf_clkgen_nco.sv
// mf_clkgen_nco: phase-accumulator clock-enable generator with per-channel phase offsets and a lock flag.
// Optional MF_CLKGEN_SYNC_UPDATE_EN defers increment updates to the next accumulator wrap.
module mf_clkgen_nco #(
  parameter int unsigned      NUM_CH     = 2,
  parameter int unsigned      ACC_W      = 32,
  parameter logic [ACC_W-1:0] INC_RESET  = ACC_W'(64'd710786810),
  parameter int unsigned      LOCK_WRAPS = 16
) (
  input  logic                    refclk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic [ACC_W-1:0]        inc_i,
  input  logic                    inc_valid,
  output logic                    inc_ready,
  input  logic [NUM_CH*ACC_W-1:0] phase_i,
  output logic [NUM_CH-1:0]       outclk,
  output logic [NUM_CH-1:0]       outclk_en,
  output logic                    locked
);

  localparam int unsigned     CNT_W   = 16;
  localparam logic [ACC_W-1:0] INC_MAX = {1'b1, {(ACC_W-1){1'b0}}};
  localparam logic [CNT_W-1:0] LOCK_TARGET = CNT_W'(LOCK_WRAPS);

  typedef enum logic [1:0] {
    ST_UNLOCKED = 2'd0,
    ST_COUNTING = 2'd1,
    ST_LOCKED   = 2'd2
  } lock_state_t;

  logic [ACC_W-1:0]  acc;
  logic [ACC_W-1:0]  inc_active;
  logic [ACC_W-1:0]  acc_sum;
  logic [ACC_W-1:0]  inc_clamped;
  logic [ACC_W-1:0]  new_inc;
  logic [ACC_W-1:0]  p_sum;
  logic [NUM_CH-1:0] p_msb;
  logic              carry;
  logic              wrap;
  logic              xfer;
  logic              apply;
  logic [CNT_W-1:0]  lock_cnt;
  lock_state_t       lock_state;

  // Accumulator add, increment clamp and per-channel phased MSBs
  always_comb begin
    {carry, acc_sum} = {1'b0, acc} + {1'b0, inc_active};
    wrap             = enable & carry;
    inc_clamped      = (inc_i > INC_MAX) ? INC_MAX : inc_i;
    xfer             = inc_valid & inc_ready;
    p_sum            = '0;
    p_msb            = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      p_sum    = acc + phase_i[c*ACC_W +: ACC_W];
      p_msb[c] = p_sum[ACC_W-1];
    end
  end

`ifdef MF_CLKGEN_SYNC_UPDATE_EN
  logic [ACC_W-1:0] shadow;
  logic             shadow_valid;

  // Pending increment lands on a wrap (or at once while stopped) so no period is cut short
  always_comb begin
    apply   = shadow_valid & (wrap | ~enable);
    new_inc = shadow;
  end

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      shadow       <= '0;
      shadow_valid <= 1'b0;
      inc_ready    <= 1'b1;
    end else if (xfer) begin
      shadow       <= inc_clamped;
      shadow_valid <= 1'b1;
      inc_ready    <= 1'b0;
    end else if (apply) begin
      shadow_valid <= 1'b0;
      inc_ready    <= 1'b1;
    end
  end
`else
  assign inc_ready = 1'b1;

  always_comb begin
    apply   = xfer;
    new_inc = inc_clamped;
  end
`endif

  // Accumulator, active increment and registered channel outputs
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      acc        <= '0;
      inc_active <= INC_RESET;
      outclk     <= '0;
      outclk_en  <= '0;
    end else begin
      if (apply) begin
        inc_active <= new_inc;
      end
      if (enable) begin
        acc       <= acc_sum;
        outclk    <= p_msb;
        outclk_en <= p_msb & ~outclk;
      end else begin
        acc       <= '0;
        outclk    <= '0;
        outclk_en <= '0;
      end
    end
  end

  // Lock FSM: count wraps after any frequency change before declaring lock
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      lock_state <= ST_UNLOCKED;
      lock_cnt   <= '0;
      locked     <= 1'b0;
    end else if (!enable || apply) begin
      lock_state <= ST_UNLOCKED;
      lock_cnt   <= '0;
      locked     <= 1'b0;
    end else begin
      case (lock_state)
        ST_UNLOCKED: begin
          lock_state <= ST_COUNTING;
          locked     <= 1'b0;
        end
        ST_COUNTING: begin
          if (lock_cnt == LOCK_TARGET) begin
            lock_state <= ST_LOCKED;
            locked     <= 1'b1;
          end else if (wrap) begin
            lock_cnt <= lock_cnt + CNT_W'(1);
          end
        end
        ST_LOCKED: begin
          locked <= 1'b1;
        end
        default: begin
          lock_state <= ST_UNLOCKED;
          lock_cnt   <= '0;
          locked     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mf_clkgen_nco.sv
// tb_mf_clkgen_nco: directed table-driven bench for mf_clkgen_nco at ACC_W=8, NUM_CH=2, INC_RESET=64, LOCK_WRAPS=4.
module tb_mf_clkgen_nco;

  localparam int unsigned NUM_CH     = 2;
  localparam int unsigned ACC_W      = 8;
  localparam int unsigned LOCK_WRAPS = 4;
  localparam int unsigned NVEC       = 26;

  logic                    refclk = 1'b0;
  logic                    rst_n;
  logic                    enable;
  logic [ACC_W-1:0]        inc_i;
  logic                    inc_valid;
  logic                    inc_ready;
  logic [NUM_CH*ACC_W-1:0] phase_i;
  logic [NUM_CH-1:0]       outclk;
  logic [NUM_CH-1:0]       outclk_en;
  logic                    locked;

  int passed = 0;
  int total  = 0;

  always #5 refclk = ~refclk;

  mf_clkgen_nco #(
    .NUM_CH    (NUM_CH),
    .ACC_W     (ACC_W),
    .INC_RESET (8'd64),
    .LOCK_WRAPS(LOCK_WRAPS)
  ) dut (
    .refclk   (refclk),
    .rst_n    (rst_n),
    .enable   (enable),
    .inc_i    (inc_i),
    .inc_valid(inc_valid),
    .inc_ready(inc_ready),
    .phase_i  (phase_i),
    .outclk   (outclk),
    .outclk_en(outclk_en),
    .locked   (locked)
  );

  typedef struct {
    logic       en;
    logic [7:0] ph1;
    logic [1:0] clk;
    logic [1:0] pulse;
    logic       lck;
  } vec_t;

  vec_t vecs [NVEC];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge refclk);
    @(negedge refclk);
  endtask

  initial begin
    int rise_a;
    int rise_b;
    int lock_at;
    int exp_rise_a;
    int exp_rise_b;
    int exp_lock_at;

    // Steady-state pattern at inc=64: outputs after edge e repeat with e mod 4; lock after edge 17
    for (int g = 0; g < 5; g++) begin
      vecs[4*g+0] = '{1'b1, 8'd128, 2'b10, 2'b10, (g >= 4)};
      vecs[4*g+1] = '{1'b1, 8'd128, 2'b10, 2'b00, (g >= 4)};
      vecs[4*g+2] = '{1'b1, 8'd128, 2'b01, 2'b01, (g >= 4)};
      vecs[4*g+3] = '{1'b1, 8'd128, 2'b01, 2'b00, (g >= 4)};
    end
    vecs[20] = '{1'b1, 8'd64,  2'b00, 2'b00, 1'b1};
    vecs[21] = '{1'b1, 8'd64,  2'b10, 2'b10, 1'b1};
    vecs[22] = '{1'b1, 8'd64,  2'b11, 2'b01, 1'b1};
    vecs[23] = '{1'b1, 8'd64,  2'b01, 2'b00, 1'b1};
    vecs[24] = '{1'b0, 8'd128, 2'b00, 2'b00, 1'b0};
    vecs[25] = '{1'b1, 8'd128, 2'b10, 2'b10, 1'b0};

    rst_n     = 1'b0;
    enable    = 1'b0;
    inc_valid = 1'b0;
    inc_i     = '0;
    phase_i   = {8'd128, 8'd0};
    step();
    step();
    check("reset outclk", 32'(outclk), 32'd0);
    check("reset outclk_en", 32'(outclk_en), 32'd0);
    check("reset locked", 32'(locked), 32'd0);
    check("reset inc_ready", 32'(inc_ready), 32'd1);

    rst_n = 1'b1;
    step();

    for (int i = 0; i < int'(NVEC); i++) begin
      enable  = vecs[i].en;
      phase_i = {vecs[i].ph1, 8'd0};
      step();
      check($sformatf("vec%0d outclk", i), 32'(outclk), 32'(vecs[i].clk));
      check($sformatf("vec%0d outclk_en", i), 32'(outclk_en), 32'(vecs[i].pulse));
      check($sformatf("vec%0d locked", i), 32'(locked), 32'(vecs[i].lck));
      check($sformatf("vec%0d inc_ready", i), 32'(inc_ready), 32'd1);
    end

    // Run to lock, then asynchronous reset mid-period
    for (int i = 0; i < 20; i++) step();
    check("prelock locked", 32'(locked), 32'd1);
    check("prelock outclk", 32'(outclk), 32'b10);
    rst_n = 1'b0;
    #1;
    check("async rst outclk", 32'(outclk), 32'd0);
    check("async rst outclk_en", 32'(outclk_en), 32'd0);
    check("async rst locked", 32'(locked), 32'd0);
    check("async rst inc_ready", 32'(inc_ready), 32'd1);
    step();
    step();

    // Restart from acc=0 and change the increment to 32 mid-period after lock
    rst_n   = 1'b1;
    enable  = 1'b1;
    phase_i = {8'd128, 8'd0};
    for (int e = 1; e <= 18; e++) begin
      step();
      if (e == 1) begin
        check("restart outclk", 32'(outclk), 32'b10);
        check("restart outclk_en", 32'(outclk_en), 32'b10);
      end
    end
    check("edge18 locked", 32'(locked), 32'd1);
    inc_i     = 8'd32;
    inc_valid = 1'b1;
    step();
`ifdef MF_CLKGEN_SYNC_UPDATE_EN
    check("xfer inc_ready", 32'(inc_ready), 32'd0);
    check("xfer locked", 32'(locked), 32'd1);
    exp_rise_a  = 21;
    exp_rise_b  = 29;
    exp_lock_at = 53;
`else
    check("xfer inc_ready", 32'(inc_ready), 32'd1);
    check("xfer locked", 32'(locked), 32'd0);
    exp_rise_a  = 22;
    exp_rise_b  = 30;
    exp_lock_at = 46;
`endif
    inc_valid = 1'b0;
    step();
    check("edge20 inc_ready", 32'(inc_ready), 32'd1);
    check("edge20 locked", 32'(locked), 32'd0);
    rise_a  = -1;
    rise_b  = -1;
    lock_at = -1;
    for (int e = 21; e <= 70; e++) begin
      step();
      if (outclk_en[1]) begin
        if (rise_a < 0) rise_a = e;
        else if (rise_b < 0) rise_b = e;
      end
      if (locked && lock_at < 0) lock_at = e;
    end
    check("new inc first ch1 rise", 32'(rise_a), 32'(exp_rise_a));
    check("new inc second ch1 rise", 32'(rise_b), 32'(exp_rise_b));
    check("relock edge", 32'(lock_at), 32'(exp_lock_at));

    // Clamp: inc_i=200 offered while stopped becomes 128, toggling every cycle
    rst_n = 1'b0;
    step();
    rst_n     = 1'b1;
    enable    = 1'b0;
    inc_i     = 8'd200;
    inc_valid = 1'b1;
    step();
    inc_valid = 1'b0;
    step();
    step();
    check("clamp inc_ready", 32'(inc_ready), 32'd1);
    enable = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      step();
      check($sformatf("clamp k%0d outclk", k), 32'(outclk),
            (k % 2 == 0) ? 32'b01 : 32'b10);
      check($sformatf("clamp k%0d outclk_en", k), 32'(outclk_en),
            (k % 2 == 0) ? 32'b01 : 32'b10);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
